// File: rtl/spi_pkg.sv
// Shared SPI definitions for the initiator and responder blocks.
// Frame-state encoding and default word width.
package spi_pkg;

  localparam int SPI_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } spi_state_e;

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period divider for the SPI initiator.
// tick marks the last clk cycle of each CLK_DIV-cycle interval.
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] div_cnt;

  assign tick = (div_cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (restart || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI initiator: one MSB-first full-duplex word per select frame.
// Frame: SETUP, 2*DATA_W clock half-periods, HOLD, then a GAP before IDLE.
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_W  = SPI_DATA_W,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              spi_clk,
  output logic              spi_sel,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);

  spi_state_e        state;
  logic [DATA_W-1:0] shift_tx;
  logic [DATA_W-1:0] shift_rx;
  logic [BW-1:0]     bit_cnt;
  logic              tick;
  logic              restart;

  // Divider is held at zero while idle so SETUP starts a fresh count.
  assign restart = (state == IDLE);

  spi_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk    (clk),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      shift_tx <= '0;
      shift_rx <= '0;
      bit_cnt  <= '0;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      spi_clk  <= 1'b0;
      spi_sel  <= 1'b1;
      spi_mosi <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            state    <= SETUP;
            shift_tx <= tx_data;
            bit_cnt  <= '0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            spi_sel  <= 1'b0;
            spi_mosi <= tx_data[DATA_W-1];
          end
        end
        SETUP: begin
          if (tick) begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (!spi_clk) begin
              spi_clk  <= 1'b1;
              shift_rx <= {shift_rx[DATA_W-2:0], spi_miso};
            end else begin
              spi_clk <= 1'b0;
              // Last falling edge: leave bit 0 on mosi.
              if (bit_cnt == LAST) begin
                state <= HOLD;
              end else begin
                bit_cnt  <= bit_cnt + BW'(1);
                shift_tx <= {shift_tx[DATA_W-2:0], 1'b0};
                spi_mosi <= shift_tx[DATA_W-2];
              end
            end
          end
        end
        HOLD: begin
          if (tick) begin
            state    <= GAP;
            spi_sel  <= 1'b1;
            spi_mosi <= 1'b0;
            rx_data  <= shift_rx;
            rx_valid <= 1'b1;
          end
        end
        GAP: begin
          if (tick) begin
            state    <= IDLE;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Initiator end of the sample SPI link: host/bench-side SPI controller that drives spi_clk/spi_sel/spi_mosi into the noise-filter chip and captures spi_miso.
- Full-duplex, mode 0 (CPOL=0, CPHA=0), MSB first, one DATA_W-bit word per chip-select frame.
- Used on the FPGA test harness and in the top-level bench as the filter's stimulus/response driver.

Parameters:
DATA_W, 16, bits per frame; must match the filter's sample width.
CLK_DIV, 4, clk cycles per spi_clk half-period; legal range is 4 or greater, because the responder synchronises spi_clk to its own clk.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
tx_data  in  DATA_W  word to transmit; sampled only on handshake
tx_valid  in  1  request to send tx_data
tx_ready  out  1  high only in IDLE; a frame is accepted when tx_valid && tx_ready
rx_data  out  DATA_W  word captured from spi_miso in the last completed frame
rx_valid  out  1  one-cycle pulse when rx_data updates
busy  out  1  high in any state other than IDLE
spi_clk  out  1  SPI clock, idles low
spi_sel  out  1  chip select, active-low, idles high
spi_mosi  out  1  serial data out, MSB first
spi_miso  in  1  serial data in, synchronous to clk

Behaviour:
- All outputs are registered.
- Reset (reset==0 at a clk edge) produces: tx_ready=1, busy=0, rx_valid=0, rx_data=0, spi_clk=0, spi_sel=1, spi_mosi=0; state=IDLE; divider and bit counter cleared.
- Reset mid-frame aborts the frame at the next edge: no rx_valid pulse, and partial rx bits are discarded.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
- Divider: div_cnt counts 0..CLK_DIV-1. tick is asserted when div_cnt==CLK_DIV-1. div_cnt restarts at 0 on each state entry.
- IDLE:
  - On tx_valid&&tx_ready, latch tx_data into shift_tx and go to SETUP.
  - spi_sel goes low in the first SETUP cycle.
  - spi_mosi is driven with tx_data[DATA_W-1] in the same cycle.
- SETUP: lasts CLK_DIV cycles; on tick go to SHIFT.
- SHIFT: 2*DATA_W ticks; spi_clk toggles on every tick.
  - Rising-edge tick: shift spi_miso into shift_rx LSB.
  - Falling-edge tick: shift shift_tx left and drive the next MSB onto spi_mosi.
  - After the DATA_W-th falling edge (spi_clk back low), go to HOLD.
  - Do not drive a new mosi bit after the last falling edge; spi_mosi holds bit 0.
- HOLD: CLK_DIV cycles with spi_sel low and spi_clk low; on tick go to GAP.
- GAP:
  - On entry: spi_sel=1, spi_mosi=0, rx_data<=shift_rx, rx_valid=1 for exactly this one cycle.
  - Lasts CLK_DIV cycles, then go to IDLE.
- IDLE lasts at least one cycle. Back-to-back: with tx_valid held high, the next accept happens in that first IDLE cycle.
- Frame timing with accept in cycle 0:
  - spi_sel low for cycles 1 .. 2*CLK_DIV*(DATA_W+1).
  - rx_valid in the next cycle.
  - tx_ready re-asserts after CLK_DIV GAP cycles.
  - Defaults: sel low cycles 1-136; rx_valid at cycle 137; IDLE/tx_ready at cycle 141.
- tx_valid while busy is ignored, and tx_data changes while busy have no effect.
- rx_data holds its value between frames.
- No overflow or underflow conditions exist: the core is single-word and unbuffered.

Decomposition:
- spi_pkg: spi_state_e enum (IDLE, SETUP, SHIFT, HOLD, GAP) and the SPI_DATA_W=16 constant, shared with the responder-side blocks.
- One sub-module, spi_sclk_gen: the div_cnt/tick generator with a restart input and a tick output.
- The FSM and shift registers stay in spi_master.

Test Plan:
1. Hold reset low for 5 cycles, then release -> spi_sel=1, spi_clk=0, spi_mosi=0, tx_ready=1, rx_data=0x0000, no rx_valid.
2. Loopback (spi_miso=spi_mosi), send 0xA5C3 -> 16 rising edges, mosi bits 1010_0101_1100_0011, spi_sel low cycles 1-136, rx_valid at cycle 137 with rx_data=0xA5C3, tx_ready at cycle 141.
3. spi_miso tied 1, send 0x0000 -> mosi stays 0 and rx_data=0xFFFF. Then tie spi_miso to 0 and send again -> rx_data=0x0000.
4. tx_valid held high with 0x1234 then 0xBEEF -> two frames, spi_sel high for exactly CLK_DIV+1=5 cycles between them, rx_valid pulses 141 cycles apart.
5. reset low at cycle 50 of a frame -> next edge gives spi_sel=1, spi_clk=0, no rx_valid. A following frame of 0x00FF in loopback returns 0x00FF.
6. Change tx_data and pulse tx_valid mid-frame -> no second accept, and the in-flight frame's mosi bits match the original word.
